descramble_lock_ctrl: RTL

Lock-acquisition and lock-monitor controller for the receive-side multiplicative descrambler. It sits directly after the descrambler on the `rclk` domain and sequences it through three states: flush (the 33-bit self-synchronising register refills), hunt (search for consecutive idle words), and locked (monitor idle density). It passes descrambled words downstream only while locked and reports lock status and lock-loss events to link management.

---
 rtl/descramble_lock_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/descramble_lock_ctrl.sv
// descramble_lock_ctrl
//   Lock acquisition / monitor for the receive-side multiplicative descrambler.
//   Sequences FLUSH (descrambler register refill) -> HUNT (consecutive idles)
//   -> LOCKED (idle density per window). Forwards words only while locked.
//
// Ports
//   rclk        in   receive word clock, rising edge
//   rst_n       in   synchronous active-low reset
//   word_valid  in   descrambled carries a new word this cycle
//   descrambled in   [9:0] descrambler output word
//   resync      in   single-cycle forced relock request
//   data_out    out  [9:0] registered copy of descrambled
//   data_valid  out  data_out is valid locked data
//   locked      out  state is LOCKED
//   lock_loss   out  one-cycle pulse on each LOCKED -> FLUSH transition
//   loss_cnt    out  [7:0] saturating lock-loss event count
module descramble_lock_ctrl #(
  parameter logic [9:0]  IDLE_WORD   = 10'h3FF,
  parameter int unsigned FLUSH_WORDS = 4,
  parameter int unsigned LOCK_CNT    = 8,
  parameter int unsigned WIN_LEN     = 64,
  parameter int unsigned MIN_IDLE    = 2
) (
  input  logic       rclk,
  input  logic       rst_n,
  input  logic       word_valid,
  input  logic [9:0] descrambled,
  input  logic       resync,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       locked,
  output logic       lock_loss,
  output logic [7:0] loss_cnt
);

  localparam int unsigned FW = $clog2(FLUSH_WORDS) + 1;
  localparam int unsigned MW = $clog2(LOCK_CNT) + 1;
  localparam int unsigned WW = $clog2(WIN_LEN) + 1;

  localparam logic [FW-1:0] FlushLast = FW'(FLUSH_WORDS);
  localparam logic [MW-1:0] LockLast  = MW'(LOCK_CNT);
  localparam logic [WW-1:0] WinLast   = WW'(WIN_LEN);
  localparam logic [WW-1:0] MinIdle   = WW'(MIN_IDLE);

  typedef enum logic [1:0] {
    StFlush,
    StHunt,
    StLocked
  } state_e;

  state_e        r_state, w_state_d;
  logic [FW-1:0] r_flush_cnt, w_flush_cnt_d;
  logic [MW-1:0] r_match_cnt, w_match_cnt_d;
  logic [WW-1:0] r_win_cnt, w_win_cnt_d;
  logic [WW-1:0] r_idle_cnt, w_idle_cnt_d;
  logic [7:0]    r_loss_cnt, w_loss_cnt_d;
  logic [9:0]    r_data_out;
  logic          r_data_valid, w_data_valid_d;
  logic          r_locked;
  logic          r_lock_loss, w_lock_loss_d;

  logic          w_is_idle;
  logic [FW-1:0] w_flush_inc;
  logic [MW-1:0] w_match_inc;
  logic [WW-1:0] w_win_inc;
  logic [WW-1:0] w_idle_inc;
  logic [7:0]    w_loss_sat;

  assign w_is_idle   = (descrambled == IDLE_WORD);
  assign w_flush_inc = r_flush_cnt + FW'(1);
  assign w_match_inc = r_match_cnt + MW'(1);
  assign w_win_inc   = r_win_cnt + WW'(1);
  // Window idle total includes the word being evaluated.
  assign w_idle_inc  = r_idle_cnt + {{(WW-1){1'b0}}, w_is_idle};
  assign w_loss_sat  = (r_loss_cnt == 8'hFF) ? r_loss_cnt : r_loss_cnt + 8'd1;

  always_comb begin
    w_state_d      = r_state;
    w_flush_cnt_d  = r_flush_cnt;
    w_match_cnt_d  = r_match_cnt;
    w_win_cnt_d    = r_win_cnt;
    w_idle_cnt_d   = r_idle_cnt;
    w_loss_cnt_d   = r_loss_cnt;
    w_lock_loss_d  = 1'b0;
    w_data_valid_d = 1'b0;

    if (resync) begin
      // Resync outranks window end and lock completion on the same word.
      if (r_state == StLocked) begin
        w_lock_loss_d = 1'b1;
        w_loss_cnt_d  = w_loss_sat;
      end
      w_state_d     = StFlush;
      w_flush_cnt_d = '0;
      w_match_cnt_d = '0;
      w_win_cnt_d   = '0;
      w_idle_cnt_d  = '0;
    end else if (word_valid) begin
      case (r_state)
        StFlush: begin
          if (w_flush_inc == FlushLast) begin
            w_state_d     = StHunt;
            w_flush_cnt_d = '0;
            w_match_cnt_d = '0;
          end else begin
            w_flush_cnt_d = w_flush_inc;
          end
        end
        StHunt: begin
          if (w_is_idle) begin
            if (w_match_inc == LockLast) begin
              w_state_d     = StLocked;
              w_match_cnt_d = '0;
              w_win_cnt_d   = '0;
              w_idle_cnt_d  = '0;
            end else begin
              w_match_cnt_d = w_match_inc;
            end
          end else begin
            w_match_cnt_d = '0;
          end
        end
        StLocked: begin
          if (w_win_inc == WinLast) begin
            w_win_cnt_d  = '0;
            w_idle_cnt_d = '0;
            if (w_idle_inc >= MinIdle) begin
              w_data_valid_d = 1'b1;
            end else begin
              w_state_d     = StFlush;
              w_flush_cnt_d = '0;
              w_lock_loss_d = 1'b1;
              w_loss_cnt_d  = w_loss_sat;
            end
          end else begin
            w_win_cnt_d    = w_win_inc;
            w_idle_cnt_d   = w_idle_inc;
            w_data_valid_d = 1'b1;
          end
        end
        default: begin
          w_state_d = StFlush;
        end
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      r_state      <= StFlush;
      r_flush_cnt  <= '0;
      r_match_cnt  <= '0;
      r_win_cnt    <= '0;
      r_idle_cnt   <= '0;
      r_loss_cnt   <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_lock_loss  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_flush_cnt  <= w_flush_cnt_d;
      r_match_cnt  <= w_match_cnt_d;
      r_win_cnt    <= w_win_cnt_d;
      r_idle_cnt   <= w_idle_cnt_d;
      r_loss_cnt   <= w_loss_cnt_d;
      if (word_valid) begin
        r_data_out <= descrambled;
      end
      r_data_valid <= w_data_valid_d;
      r_locked     <= (w_state_d == StLocked);
      r_lock_loss  <= w_lock_loss_d;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign locked     = r_locked;
  assign lock_loss  = r_lock_loss;
  assign loss_cnt   = r_loss_cnt;

endmodule
